// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe
//   Registered AES ShiftRows / InvShiftRows stage for Rijndael block widths
//   of NB = 4, 6 or 8 columns, with a 2-entry output FIFO and valid/ready
//   handshakes on both sides.
//
// Parameters
//   NB  number of state columns (4, 6 or 8; anything else fails elaboration)
//   W   state width in bits, fixed at 32*NB
//
// Ports
//   sys_clk    in   1  clock, rising edge
//   sys_rst_n  in   1  synchronous active-low reset
//   in_valid   in   1  input transfer request
//   in_ready   out  1  block can accept input this cycle
//   in_inv     in   1  0 = ShiftRows, 1 = InvShiftRows, captured with in_data
//   in_data    in   W  input state, byte 0 in the top byte, column-major
//   out_valid  out  1  out_data holds a result
//   out_ready  in   1  downstream accepts the output
//   out_data   out  W  shifted state (head FIFO entry, registered)
//   out_inv    out  1  mode used for the current out_data
//
// Optional feature (macro AES_SR_STATS_EN)
//   beat_cnt   out  16 saturating count of output transfers
//   stall_cnt  out  16 saturating count of cycles with out_valid & ~out_ready
module aes_shiftrows_pipe #(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_inv
`ifdef AES_SR_STATS_EN
  ,
  output logic [15:0]  beat_cnt,
  output logic [15:0]  stall_cnt
`endif
);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end

  // ---------------------------------------------------------------------
  // Byte permutation. Every output byte is a fixed wire from one input
  // byte, so both directions are pure routing and the mode only picks
  // between the two permuted vectors.
  // ---------------------------------------------------------------------
  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    // NB = 8 uses the wider Rijndael offsets {0,1,3,4} for rows 2 and 3.
    localparam int OFF = (NB == 8 && gi >= 2) ? gi + 1 : gi;
    for (genvar gj = 0; gj < NB; gj++) begin : g_col
      localparam int FSRC = (gj + OFF) % NB;
      localparam int ISRC = (gj - OFF + NB) % NB;
      assign fwd_data[W-1-8*(gi+4*gj) -: 8] = in_data[W-1-8*(gi+4*FSRC) -: 8];
      assign inv_data[W-1-8*(gi+4*gj) -: 8] = in_data[W-1-8*(gi+4*ISRC) -: 8];
    end
  end

  assign shifted = in_inv ? inv_data : fwd_data;

  // ---------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------
  logic [W-1:0] data_mem [0:1];
  logic         inv_mem  [0:1];
  logic         head_reg, head_next;
  logic         tail_reg, tail_next;
  logic [1:0]   count_reg, count_next;
  logic [W-1:0] out_data_reg, out_data_next;
  logic         out_inv_reg, out_inv_next;
  logic         push;
  logic         pop;

  // Ready depends only on the occupancy register (and reset), never on
  // out_ready, so no combinational path crosses the stage.
  assign in_ready  = sys_rst_n & (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    out_data_next = out_data_reg;
    out_inv_next  = out_inv_reg;

    if (push) tail_next = ~tail_reg;
    if (pop)  head_next = ~head_reg;

    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase

    // The output register mirrors the entry that will be head next cycle.
    // When that entry is the one being written right now (FIFO empty, or
    // a single entry being popped), take it straight from the permutation.
    // When the FIFO drains, the last value is simply held.
    if (count_next != 2'd0) begin
      if (push && (head_next == tail_reg)) begin
        out_data_next = shifted;
        out_inv_next  = in_inv;
      end else begin
        out_data_next = data_mem[head_next];
        out_inv_next  = inv_mem[head_next];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
      count_reg    <= 2'd0;
      out_data_reg <= '0;
      out_inv_reg  <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      out_data_reg <= out_data_next;
      out_inv_reg  <= out_inv_next;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      data_mem[tail_reg] <= shifted;
      inv_mem[tail_reg]  <= in_inv;
    end
  end

  assign out_data = out_data_reg;
  assign out_inv  = out_inv_reg;

`ifdef AES_SR_STATS_EN
  logic [15:0] beat_cnt_reg;
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      beat_cnt_reg  <= 16'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (pop && (beat_cnt_reg != 16'hFFFF))
        beat_cnt_reg <= beat_cnt_reg + 16'd1;
      if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign beat_cnt  = beat_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe: NB=4 and NB=8 instances, table vectors,
// hand-written handshake/reset sequences and random streaming against a
// byte-array reference model.
module tb_aes_shiftrows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic         v4, rdy4, inv4, ordy4, ov4, oinv4;
  logic [127:0] d4, od4;
  logic         v8, rdy8, inv8, ordy8, ov8, oinv8;
  logic [255:0] d8, od8;

  int checks   = 0;
  int failures = 0;

`ifdef AES_SR_STATS_EN
  logic [15:0] beat4, stall4, beat8, stall8;
`endif

  aes_shiftrows_pipe #(.NB(4)) dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(v4), .in_ready(rdy4), .in_inv(inv4), .in_data(d4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_inv(oinv4)
`ifdef AES_SR_STATS_EN
    , .beat_cnt(beat4), .stall_cnt(stall4)
`endif
  );

  aes_shiftrows_pipe #(.NB(8)) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_inv(inv8), .in_data(d8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_inv(oinv8)
`ifdef AES_SR_STATS_EN
    , .beat_cnt(beat8), .stall_cnt(stall8)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: unpack into a byte array, rotate each row by its offset,
  // repack. State is right-aligned in the low 32*nb bits.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input bit inv, input int nb);
    logic [7:0] b_in  [32];
    logic [7:0] b_out [32];
    int offs [4];
    int w;
    int src;
    logic [255:0] r;
    w = 32 * nb;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int k = 0; k < 4 * nb; k++) b_in[k] = d[w-1-8*k -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < nb; col++) begin
        src = inv ? (col - offs[row] + nb) % nb : (col + offs[row]) % nb;
        b_out[row + 4*col] = b_in[row + 4*src];
      end
    r = '0;
    for (int k = 0; k < 4 * nb; k++) r[w-1-8*k -: 8] = b_out[k];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  initial begin
    vec_t         tbl [5];
    logic [127:0] a, b, c;
    logic [255:0] exp_v;

    tbl[0] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b0, 128'h00050A0F04090E03080D02070C01060B};
    tbl[1] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b1, 128'h000D0A0704010E0B0805020F0C090603};
    tbl[2] = '{128'h00050A0F04090E03080D02070C01060B, 1'b1, 128'h000102030405060708090A0B0C0D0E0F};
    tbl[3] = '{128'hABABABABABABABABABABABABABABABAB, 1'b0, 128'hABABABABABABABABABABABABABABABAB};
    tbl[4] = '{128'h11223344112233441122334411223344, 1'b1, 128'h11223344112233441122334411223344};

    rst_n = 1'b0;
    v4 = 1'b0; inv4 = 1'b0; d4 = '0; ordy4 = 1'b0;
    v8 = 1'b0; inv8 = 1'b0; d8 = '0; ordy8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", ov4, 0);
    check("rst_in_ready_low", rdy4, 0);
    check("rst_out_data", od4, 0);
    check("rst_out_inv", oinv4, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", rdy4, 1);

    // Table vectors, NB=4
    ordy4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d4 = tbl[i].din; inv4 = tbl[i].inv; v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
      check("tbl_valid", ov4, 1);
      check("tbl_data", od4, tbl[i].exp);
      check("tbl_inv", oinv4, tbl[i].inv);
      $display("vec %0d in=%h inv=%0d out=%h", i, tbl[i].din, tbl[i].inv, od4);
      @(posedge clk); #1;
      check("tbl_drain", ov4, 0);
    end

    // NB=8 ascending bytes, forward
    for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
    inv8 = 1'b0; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    check("nb8_valid", ov8, 1);
    check("nb8_col0", od8[255:224], 32'h00050E13);
    check("nb8_full", od8, ref_shift(d8, 1'b0, 8));
    $display("nb8 fwd out=%h", od8);
    @(posedge clk); #1;

    // NB=8 random back-to-back beats
    for (int i = 0; i < 8; i++) begin
      d8 = {rnd128(), rnd128()}; inv8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
      exp_v = ref_shift(d8, inv8, 8);
      @(posedge clk); #1;
      check("nb8_rand_data", od8, exp_v);
      check("nb8_rand_inv", oinv8, inv8);
      $display("nb8 beat %0d inv=%0d out=%h", i, inv8, od8);
    end
    v8 = 1'b0;
    @(posedge clk); #1;
    check("nb8_drain", ov8, 0);

    // Backpressure: three beats presented with out_ready low
    a = rnd128(); b = rnd128(); c = rnd128();
    ordy4 = 1'b0;
    d4 = a; inv4 = 1'b0; v4 = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_1", rdy4, 1);
    check("bp_head_a", od4, ref_shift({128'b0, a}, 1'b0, 4));
    d4 = b; inv4 = 1'b1;
    @(posedge clk); #1;
    check("bp_full_ready", rdy4, 0);
    check("bp_full_valid", ov4, 1);
    d4 = c; inv4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_ready", rdy4, 0);
    check("bp_hold_a", od4, ref_shift({128'b0, a}, 1'b0, 4));
    check("bp_hold_inv_a", oinv4, 0);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    check("bp_out_b", od4, ref_shift({128'b0, b}, 1'b1, 4));
    check("bp_inv_b", oinv4, 1);
    check("bp_ready_reopen", rdy4, 1);
    $display("bp beat b out=%h inv=%0d", od4, oinv4);
    @(posedge clk); #1;
    v4 = 1'b0;
    check("bp_valid_c", ov4, 1);
    check("bp_out_c", od4, ref_shift({128'b0, c}, 1'b0, 4));
    check("bp_inv_c", oinv4, 0);
    $display("bp beat c out=%h inv=%0d", od4, oinv4);
    @(posedge clk); #1;
    check("bp_empty", ov4, 0);

    // Reset while full
    ordy4 = 1'b0;
    d4 = rnd128(); inv4 = 1'b1; v4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v4 = 1'b0;
    check("rf_full", rdy4, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rf_valid", ov4, 0);
    check("rf_data", od4, 0);
    check("rf_inv", oinv4, 0);
    check("rf_ready_in_rst", rdy4, 0);
    rst_n = 1'b1;
    #1;
    check("rf_ready_release", rdy4, 1);
    ordy4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rf_no_stale", ov4, 0);
    end

    // Streaming: 100 random beats, out_ready held high
    ordy4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d4 = rnd128(); inv4 = 1'($urandom_range(0, 1)); v4 = 1'b1;
      exp_v = ref_shift({128'b0, d4}, inv4, 4);
      @(posedge clk); #1;
      check("stream_valid", ov4, 1);
      check("stream_ready", rdy4, 1);
      check("stream_data", od4, exp_v);
      check("stream_inv", oinv4, inv4);
      $display("stream %0d inv=%0d out=%h", i, inv4, od4);
    end
    v4 = 1'b0;
    @(posedge clk); #1;
    check("stream_drain", ov4, 0);
`ifdef AES_SR_STATS_EN
    check("stats_beat_cnt", beat4, 100);
    check("stats_stall_cnt", stall4, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
